// File: rtl/tdc_spi_pkg.sv
// rtl/tdc_spi_pkg.sv - command codes, record widths and SPI FSM state for the TDC readout
package tdc_spi_pkg;

    localparam logic [7:0] CMD_READ   = 8'h01;
    localparam logic [7:0] CMD_STATUS = 8'h02;
    localparam logic [7:0] CMD_CLEAR  = 8'h03;

    localparam int REC_W            = 48;
    localparam int RESP_BITS_READ   = 48;
    localparam int RESP_BITS_STATUS = 8;
    localparam int CMD_BITS         = 8;

    typedef enum logic [1:0] {
        SPI_IDLE,
        SPI_CMD,
        SPI_RESP,
        SPI_DONE
    } spi_state_e;

endpackage

// File: rtl/tdc_result_fifo.sv
// rtl/tdc_result_fifo.sv - record FIFO with same-cycle push/pop (also when full) and flush
module tdc_result_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 48,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // A pop frees the head slot in the same cycle, so a push into a full FIFO still fits.
    assign pop_ok  = pop && !flush && !empty;
    assign push_ok = push && !flush && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/tdc_result_spi.sv
// rtl/tdc_result_spi.sv - captures TDC results into a tagged FIFO and serves them over an oversampled SPI slave
module tdc_result_spi
    import tdc_spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SEQ_W      = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tdc_busy,
    input  logic [31:0] coarse_result,
    input  logic [8:0]  fine_result,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        data_ready,
    output logic        overflow
);

    localparam int         CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [6:0] POP_BITS = 7'(CMD_BITS + RESP_BITS_READ);

    logic [1:0] busy_sync, sclk_sync, cs_sync, mosi_sync;
    logic       busy_d, sclk_d, cs_d;
    logic       busy_s, sclk_s, cs_s, mosi_s;
    logic       capture, sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [SEQ_W-1:0] seq;
    logic [REC_W-1:0] fifo_rdata;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty, fifo_pop, flush;
    logic [7:0]       status;

    spi_state_e       state, state_nxt;
    logic             decode;
    logic [6:0]       bit_cnt;
    logic [6:0]       cmd_sr;
    logic [7:0]       cmd_byte;
    logic [7:0]       cmd_q;
    logic             read_valid;
    logic [REC_W-1:0] resp_sr;
    logic             miso_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_sync <= 2'b00;
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            busy_d    <= 1'b0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            busy_sync <= {busy_sync[0], tdc_busy};
            sclk_sync <= {sclk_sync[0], spi_sclk};
            cs_sync   <= {cs_sync[0], spi_cs_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            busy_d    <= busy_s;
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign busy_s    = busy_sync[1];
    assign sclk_s    = sclk_sync[1];
    assign cs_s      = cs_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign capture   = busy_d & ~busy_s;
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    tdc_result_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (REC_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (capture),
        .pop   (fifo_pop),
        .flush (flush),
        .wdata ({seq, fine_result, coarse_result}),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // seq advances on every capture event, even dropped or flushed ones, so gaps reveal losses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq        <= '0;
            overflow   <= 1'b0;
            data_ready <= 1'b0;
        end else begin
            if (capture) begin
                seq <= seq + SEQ_W'(1);
            end
            if (flush) begin
                overflow <= 1'b0;
            end else if (capture && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
            data_ready <= ~fifo_empty;
        end
    end

    assign status   = {4'(fifo_count), overflow, busy_s, fifo_full, fifo_empty};
    assign cmd_byte = {cmd_sr, mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SPI_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        decode    = 1'b0;
        fifo_pop  = 1'b0;
        flush     = 1'b0;
        if (cs_rise) begin
            state_nxt = SPI_IDLE;
            if (state == SPI_RESP) begin
                flush    = (cmd_q == CMD_CLEAR);
                fifo_pop = (cmd_q == CMD_READ) && read_valid && (bit_cnt >= POP_BITS);
            end
        end else if (cs_fall) begin
            state_nxt = SPI_CMD;
        end else if (state == SPI_CMD && sclk_rise && bit_cnt == 7'(CMD_BITS - 1)) begin
            decode = 1'b1;
            if (cmd_byte == CMD_READ || cmd_byte == CMD_STATUS || cmd_byte == CMD_CLEAR) begin
                state_nxt = SPI_RESP;
            end else begin
                state_nxt = SPI_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            cmd_sr     <= '0;
            cmd_q      <= '0;
            read_valid <= 1'b0;
            resp_sr    <= '0;
            miso_q     <= 1'b0;
        end else if (cs_fall) begin
            bit_cnt    <= '0;
            cmd_sr     <= '0;
            cmd_q      <= '0;
            read_valid <= 1'b0;
            resp_sr    <= '0;
            miso_q     <= 1'b0;
        end else if (cs_rise || state == SPI_IDLE) begin
            miso_q <= 1'b0;
        end else begin
            if (sclk_rise) begin
                if (bit_cnt != 7'h7F) begin
                    bit_cnt <= bit_cnt + 7'd1;
                end
                if (state == SPI_CMD) begin
                    cmd_sr <= cmd_byte[6:0];
                end
            end
            // Response is snapshotted here; later pushes cannot disturb a frame in flight.
            if (decode) begin
                cmd_q      <= cmd_byte;
                read_valid <= ~fifo_empty;
                case (cmd_byte)
                    CMD_READ:   resp_sr <= fifo_empty ? '0 : fifo_rdata;
                    CMD_STATUS: resp_sr <= {status, {(REC_W - RESP_BITS_STATUS){1'b0}}};
                    default:    resp_sr <= '0;
                endcase
            end
            if (sclk_fall) begin
                if (state == SPI_RESP) begin
                    miso_q  <= resp_sr[REC_W-1];
                    resp_sr <= {resp_sr[REC_W-2:0], 1'b0};
                end else begin
                    miso_q <= 1'b0;
                end
            end
        end
    end

    assign spi_miso = miso_q & ~spi_cs_n;

endmodule

// File: tb/tb_tdc_result_spi.sv
// tb/tb_tdc_result_spi.sv - self-checking bench for tdc_result_spi against a queue-based model
module tb_tdc_result_spi;
    import tdc_spi_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tdc_busy = 1'b0;
    logic [31:0] coarse_result = '0;
    logic [8:0]  fine_result = '0;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso, data_ready, overflow;

    always #5 clk = ~clk;

    tdc_result_spi #(.FIFO_DEPTH(DEPTH), .SEQ_W(7)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tdc_busy      (tdc_busy),
        .coarse_result (coarse_result),
        .fine_result   (fine_result),
        .spi_sclk      (spi_sclk),
        .spi_cs_n      (spi_cs_n),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .data_ready    (data_ready),
        .overflow      (overflow)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [47:0] mq[$];
    logic [6:0]  m_seq = '0;
    logic        m_ovf = 1'b0;

    typedef struct {
        logic [31:0] coarse;
        logic [8:0]  fine;
        logic [47:0] exp;
    } vec_t;
    vec_t tbl[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_seq = '0;
        m_ovf = 1'b0;
    endtask

    task automatic model_capture(input logic [31:0] c, input logic [8:0] f);
        if (mq.size() < DEPTH) mq.push_back({m_seq, f, c});
        else m_ovf = 1'b1;
        m_seq = m_seq + 7'd1;
    endtask

    function automatic logic [7:0] model_status();
        logic [3:0] cnt;
        cnt = 4'(mq.size());
        return {cnt, m_ovf, 1'b0, mq.size() == DEPTH, mq.size() == 0};
    endfunction

    task automatic do_capture(input logic [31:0] c, input logic [8:0] f);
        coarse_result = c;
        fine_result   = f;
        tdc_busy = 1'b1;
        cyc(4);
        tdc_busy = 1'b0;
        cyc(8);
        model_capture(c, f);
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input int nbits, input bit keep_cs,
                             output logic [63:0] rx);
        rx = '0;
        spi_cs_n = 1'b0;
        cyc(4);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 8) ? cmd[7-i] : 1'b0;
            cyc(4);
            rx = {rx[62:0], spi_miso};
            spi_sclk = 1'b1;
            cyc(4);
            spi_sclk = 1'b0;
        end
        cyc(4);
        if (!keep_cs) begin
            spi_cs_n = 1'b1;
            cyc(6);
        end
    endtask

    // Model view of a READ: head (or zeros), popped only by a complete frame.
    task automatic model_read(input int nbits, output logic [63:0] exp_obs);
        logic [47:0] rec;
        rec = (mq.size() > 0) ? mq[0] : '0;
        if (nbits >= 56 && mq.size() > 0) void'(mq.pop_front());
        exp_obs = 64'(rec) >> (56 - nbits);
    endtask

    task automatic do_read(input string name, input int nbits, output logic [63:0] rx);
        logic [63:0] exp_obs;
        spi_frame(CMD_READ, nbits, 1'b0, rx);
        model_read(nbits, exp_obs);
        check(name, rx, exp_obs);
    endtask

    task automatic do_status(input string name, output logic [63:0] rx);
        spi_frame(CMD_STATUS, 16, 1'b0, rx);
        check(name, rx, 64'(model_status()));
    endtask

    task automatic do_clear();
        logic [63:0] rx;
        spi_frame(CMD_CLEAR, 16, 1'b0, rx);
        mq.delete();
        m_ovf = 1'b0;
    endtask

    task automatic check_flags(input string name);
        check({name, "_ready"}, data_ready, mq.size() > 0);
        check({name, "_ovf"}, overflow, m_ovf);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        model_reset();
        cyc(2);
    endtask

    initial begin
        logic [63:0] rx;
        int op;

        tbl[0] = '{32'h0000_0005, 9'h0A3, 48'h00A3_0000_0005};
        tbl[1] = '{32'hFFFF_FFFF, 9'h1FF, 48'h03FF_FFFF_FFFF};
        tbl[2] = '{32'h1234_5678, 9'h000, 48'h0400_1234_5678};
        tbl[3] = '{32'hDEAD_BEEF, 9'h155, 48'h0755_DEAD_BEEF};

        cyc(3);
        check("rst_miso", spi_miso, 0);
        check("rst_ready", data_ready, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        cyc(2);

        for (int i = 0; i < 4; i++) begin
            coarse_result = tbl[i].coarse;
            fine_result   = tbl[i].fine;
            tdc_busy = 1'b1;
            cyc(4);
            tdc_busy = 1'b0;
            cyc(3);
            check("ready_lat3", data_ready, 0);
            cyc(1);
            check("ready_lat4", data_ready, 1);
            model_capture(tbl[i].coarse, tbl[i].fine);
            cyc(4);
            do_read("tbl_read_model", 56, rx);
            check("tbl_read_const", rx, 64'(tbl[i].exp));
            check("tbl_ready_after_pop", data_ready, 0);
        end

        pulse_reset();
        for (int i = 0; i < 5; i++) do_capture(32'h100 + i, 9'(i));
        do_status("ovf_status_model", rx);
        check("ovf_status_const", rx, 64'h4A);
        check("ovf_flag", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            do_read("ovf_read", 56, rx);
            check("ovf_read_seq", rx[47:41], i);
        end
        do_capture(32'hCAFE, 9'h011);
        do_read("next_seq_read", 56, rx);
        check("next_seq", rx[47:41], 5);

        do_read("empty_read", 56, rx);
        check("empty_read_zero", rx, 0);
        do_status("empty_status", rx);
        check_flags("empty");

        do_capture(32'hA5A5_0001, 9'h0F0);
        do_read("short_read", 20, rx);
        do_status("short_status", rx);
        do_read("after_short_read", 56, rx);
        check("after_short_seq", rx[47:41], 6);

        do_clear();
        do_status("clear_status_model", rx);
        check("clear_status_const", rx, 64'h01);
        for (int i = 0; i < 4; i++) do_capture(32'h200 + i, 9'h1A0 + 9'(i));
        coarse_result = 32'h0BAD_F00D;
        fine_result   = 9'h077;
        tdc_busy = 1'b1;
        cyc(4);
        spi_frame(CMD_READ, 56, 1'b1, rx);
        begin
            logic [63:0] exp_obs;
            model_read(56, exp_obs);
            check("simul_read", rx, exp_obs);
        end
        tdc_busy = 1'b0;
        spi_cs_n = 1'b1;
        cyc(8);
        model_capture(32'h0BAD_F00D, 9'h077);
        do_status("simul_status_model", rx);
        check("simul_status_const", rx, 64'h42);
        check("simul_ovf", overflow, 0);

        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 5);
            case (op)
                0, 1: do_capture($urandom, 9'($urandom_range(0, 511)));
                2: do_read("rnd_read", 56, rx);
                3: do_read("rnd_short", $urandom_range(9, 55), rx);
                4: do_status("rnd_status", rx);
                default: do_clear();
            endcase
            check_flags("rnd");
        end

        do_capture(32'h7777_0000, 9'h101);
        do_capture(32'h7777_0001, 9'h102);
        spi_frame(CMD_READ, 20, 1'b1, rx);
        rst_n = 1'b0;
        #1;
        check("midrst_miso", spi_miso, 0);
        cyc(2);
        check("midrst_ready", data_ready, 0);
        check("midrst_ovf", overflow, 0);
        spi_cs_n = 1'b1;
        rst_n = 1'b1;
        model_reset();
        cyc(4);
        do_status("midrst_status", rx);
        do_capture(32'h0000_0042, 9'h003);
        do_read("midrst_read", 56, rx);
        check("midrst_seq0", rx[47:41], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
